kw_arb_wrr: RTL

//  N-way weighted round-robin arbiter; successor to the static-priority arbiter (KW_arb_sp).

---
 rtl/kw_arb_wrr_if.sv | 28 ++
 rtl/kw_arb_wrr.sv | 105 ++++++++++
 2 files changed

// File: rtl/kw_arb_wrr_if.sv
// Arbiter request/grant bundle: clients drive request/mask/lock/weight,
// the arbiter returns the registered grant and its status flags.
interface kw_arb_wrr_if #(
  parameter int N  = 16,
  parameter int WW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    request;
  logic [N-1:0]    mask;
  logic [N-1:0]    lock;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_index;
  logic            parked;
  logic            granted;
  logic            locked;

  modport master (
    output request, mask, lock, weight,
    input  grant, grant_index, parked, granted, locked
  );

  modport slave (
    input  request, mask, lock, weight,
    output grant, grant_index, parked, granted, locked
  );
endinterface

// File: rtl/kw_arb_wrr.sv
// N-way weighted round-robin arbiter with burst credit, lock hold,
// request masking and optional parking of the idle grant.
module kw_arb_wrr #(
  parameter int N          = 16,
  parameter int WW         = 4,
  parameter int PARK_MODE  = 1,
  parameter int PARK_INDEX = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  kw_arb_wrr_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  PARK_GRANT = (PARK_MODE != 0) ? (N'(1) << PARK_INDEX) : '0;
  localparam logic [IW-1:0] PARK_IDX   = (PARK_MODE != 0) ? IW'(PARK_INDEX) : '0;
  localparam logic          PARK_FLAG  = (PARK_MODE != 0);

  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          parked_q, parked_d;
  logic          granted_q, granted_d;
  logic          locked_q, locked_d;

  logic [N-1:0]  req_eff;
  logic [IW-1:0] cand;
  logic [IW-1:0] hit_idx;
  logic          hit_found;
  logic [WW-1:0] hit_weight;

  assign req_eff = bus.request & ~bus.mask;

  // Rotating search starts just past the last winner, so the previous owner comes last.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!hit_found && req_eff[cand]) begin
        hit_found = 1'b1;
        hit_idx   = cand;
      end
    end
    hit_weight = bus.weight[int'(hit_idx)*WW +: WW];
  end

  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    parked_d  = parked_q;
    granted_d = granted_q;
    locked_d  = locked_q;
    if (granted_q && bus.request[owner_q] && bus.lock[owner_q]) begin
      locked_d = 1'b1;
    end else if (granted_q && req_eff[owner_q] && cnt_q != '0) begin
      cnt_d    = cnt_q - 1'b1;
      locked_d = 1'b0;
    end else if (hit_found) begin
      grant_d          = '0;
      grant_d[hit_idx] = 1'b1;
      owner_d          = hit_idx;
      ptr_d            = hit_idx;
      cnt_d            = (hit_weight == '0) ? '0 : hit_weight - 1'b1;
      granted_d        = 1'b1;
      parked_d         = 1'b0;
      locked_d         = 1'b0;
    end else begin
      grant_d   = PARK_GRANT;
      owner_d   = PARK_IDX;
      parked_d  = PARK_FLAG;
      granted_d = 1'b0;
      locked_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q   <= PARK_GRANT;
      owner_q   <= PARK_IDX;
      ptr_q     <= IW'(N - 1);
      cnt_q     <= '0;
      parked_q  <= PARK_FLAG;
      granted_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      parked_q  <= parked_d;
      granted_q <= granted_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = owner_q;
  assign bus.parked      = parked_q;
  assign bus.granted     = granted_q;
  assign bus.locked      = locked_q;
endmodule
